inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_BITS, default 10, log2 of instruction memory depth in words (depth 1024).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx_data  input  8  incoming program byte.
REQ-006 SHALL have port rx_valid  input  1  rx_data valid.
REQ-007 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port program_counter  input  WIDTH  byte address from core.
REQ-009 SHALL have port inst  output  WIDTH  instruction for program_counter.
REQ-010 SHALL have port core_rstn  output  1  active-low reset to core, released after load.
REQ-011 SHALL have port load_done  output  1  high in RUN state.
REQ-012 SHALL have port load_err  output  1  high in ERR state.

Function
REQ-013 SHALL implement FSM states HDR, LOAD, RUN, ERR; byte accepted iff rx_valid && rx_ready on a clock edge.
REQ-014 rx_ready SHALL be 1 in HDR and LOAD, 0 in RUN and ERR.
REQ-015 HDR: collect 4 accepted bytes, big-endian, into 32-bit word count N; byte counter 0..3 wraps after 4th byte.
REQ-016 On 4th header byte: N==0 -> RUN; N > 2^ADDR_BITS -> ERR; else -> LOAD with word index k=0.
REQ-017 LOAD: each 4 accepted bytes form one big-endian word; on the edge accepting the 4th byte, mem[k] SHALL be written with the full word (including that byte) and k incremented.
REQ-018 Writing word k==N-1 SHALL move FSM to RUN on the same edge.
REQ-019 Idle cycles (rx_valid=0) SHALL not advance byte or word counters in any state.
REQ-020 core_rstn, load_done, load_err SHALL be registered, matching state: core_rstn=1 and load_done=1 only in RUN; load_err=1 only in ERR.
REQ-021 inst SHALL be combinational from program_counter (zero latency, single-cycle core): index = program_counter[ADDR_BITS+1:2]; program_counter[1:0] and upper bits ignored.
REQ-022 inst SHALL be 0 (nop) when state != RUN or index >= N.
REQ-023 RUN and ERR SHALL be terminal until rstn asserted; bytes presented there are ignored.
REQ-024 Memory SHALL have one write port (LOAD only) and one asynchronous read port.

Reset
REQ-025 rstn=0 SHALL immediately force state HDR, byte counter 0, k=0, N=0, core_rstn=0, load_done=0, load_err=0, rx_ready=1 (after release).
REQ-026 Reset mid-LOAD SHALL discard partial word and restart at HDR; memory contents need not be cleared, but inst reads 0 via REQ-022 until new load completes.

Verification
REQ-027 Header 00 00 00 02, words 0x20010005, 0x00221820 back-to-back -> load_done=1 and core_rstn=1 on edge accepting 12th byte; pc=0 -> inst=0x20010005, pc=4 -> 0x00221820, pc=8 -> 0.
REQ-028 Same stream with rx_valid toggled 1/0 every cycle -> identical memory contents and completion after 12 accepted bytes (23 cycles).
REQ-029 Header 00 00 00 00 -> RUN after 4th byte, inst=0 for every pc, rx_ready=0.
REQ-030 Header 00 00 04 01 (1025) -> load_err=1, core_rstn stays 0, rx_ready=0, further bytes ignored.
REQ-031 rstn pulsed low after 6 of 12 bytes, then full 12-byte stream -> result identical to REQ-027; inst=0 throughout reload.
REQ-032 In RUN, pc=0x00000006 and pc=0x00001004 (ADDR_BITS=10) -> inst equals mem[1] contents, i.e. low bits ignored and index masked.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: boot-time program loader and instruction memory for a
// single-cycle core.
//
// A byte stream arrives on rx_data/rx_valid. The first four accepted bytes
// form a big-endian word count N. The next 4*N bytes form N big-endian
// instruction words, which are written to mem[0..N-1]. Once the last word is
// written, the core is released from reset and instruction fetches are served.
//
// Ports
//   clk             in   1      single clock, rising edge
//   rstn            in   1      asynchronous active-low reset
//   rx_data         in   8      incoming program byte
//   rx_valid        in   1      rx_data valid
//   rx_ready        out  1      byte accepted this cycle when rx_valid is also high
//   program_counter in   WIDTH  byte address from the core
//   inst            out  WIDTH  instruction at program_counter (combinational)
//   core_rstn       out  1      active-low core reset, released in RUN
//   load_done       out  1      high in RUN
//   load_err        out  1      high in ERR (header count exceeds memory depth)
module inst_loader #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [WIDTH-1:0] program_counter,
  output logic [WIDTH-1:0] inst,
  output logic             core_rstn,
  output logic             load_done,
  output logic             load_err
);

  localparam int          DEPTH_WORDS = 1 << ADDR_BITS;
  localparam logic [31:0] DEPTH       = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [1:0]             byte_cnt_r;
  logic [23:0]            shift_r;
  logic [31:0]            n_r;
  logic [ADDR_BITS-1:0]   k_r;
  logic                   accept_s;
  logic                   fourth_s;
  logic [31:0]            word_s;
  logic                   last_word_s;
  logic                   mem_we_s;
  logic [ADDR_BITS-1:0]   rd_idx_s;
  logic                   unused_pc_bits;

  logic [WIDTH-1:0] mem [0:DEPTH_WORDS-1];

  // Ready is a pure decode of the state register, so it is glitch-free.
  assign rx_ready = (state_r == HDR) || (state_r == LOAD);
  assign accept_s = rx_valid && rx_ready;
  assign fourth_s = accept_s && (byte_cnt_r == 2'd3);

  // The completed word includes the byte being accepted on this edge.
  assign word_s      = {shift_r, rx_data};
  assign last_word_s = (32'(k_r) == (n_r - 32'd1));

  // Word index ignores the byte offset and any address bits above the memory.
  assign rd_idx_s       = program_counter[ADDR_BITS+1:2];
  assign unused_pc_bits = ^{program_counter[WIDTH-1:ADDR_BITS+2], program_counter[1:0]};

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= HDR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and memory write strobe.
  always_comb begin
    state_next_s = state_r;
    mem_we_s     = 1'b0;
    case (state_r)
      HDR: begin
        if (fourth_s) begin
          if (word_s == 32'd0) begin
            state_next_s = RUN;
          end else if (word_s > DEPTH) begin
            state_next_s = ERR;
          end else begin
            state_next_s = LOAD;
          end
        end else begin
          state_next_s = HDR;
        end
      end
      LOAD: begin
        if (fourth_s) begin
          mem_we_s = 1'b1;
          if (last_word_s) begin
            state_next_s = RUN;
          end else begin
            state_next_s = LOAD;
          end
        end else begin
          state_next_s = LOAD;
        end
      end
      RUN:     state_next_s = RUN;
      ERR:     state_next_s = ERR;
      default: state_next_s = HDR;
    endcase
  end

  // Byte assembly, header count and word index; they only move on accepted bytes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt_r <= 2'd0;
      shift_r    <= 24'd0;
      n_r        <= 32'd0;
      k_r        <= {ADDR_BITS{1'b0}};
    end else if (accept_s) begin
      byte_cnt_r <= byte_cnt_r + 2'd1;
      shift_r    <= {shift_r[15:0], rx_data};
      if (byte_cnt_r == 2'd3) begin
        if (state_r == HDR) begin
          n_r <= word_s;
          k_r <= {ADDR_BITS{1'b0}};
        end else begin
          k_r <= k_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Status outputs follow the state being entered, so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_rstn <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      core_rstn <= (state_next_s == RUN);
      load_done <= (state_next_s == RUN);
      load_err  <= (state_next_s == ERR);
    end
  end

  // Single write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[k_r] <= WIDTH'(word_s);
    end
  end

  // Asynchronous fetch; words beyond the loaded count, or any fetch before
  // loading completes, return a nop.
  always_comb begin
    inst = {WIDTH{1'b0}};
    if ((state_r == RUN) && (32'(rd_idx_s) < n_r)) begin
      inst = mem[rd_idx_s];
    end else begin
      inst = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader. A reference model keeps the list of
// bytes the loader should have accepted and derives every expected output
// from that list: the header count, the phase (header/loading/running/error)
// and the instruction image.
module tb_inst_loader;

  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 10;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic             clk = 1'b0;
  logic             rstn;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] program_counter;
  logic [WIDTH-1:0] inst;
  logic             core_rstn;
  logic             load_done;
  logic             load_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] acc[$];   // bytes the loader should have accepted since reset
  logic [7:0] strm[$];  // stream under construction

  inst_loader #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .program_counter (program_counter),
    .inst            (inst),
    .core_rstn       (core_rstn),
    .load_done       (load_done),
    .load_err        (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model -------------------------------------------------
  function automatic longint m_n();
    if (acc.size() < 4) return 0;
    return longint'({acc[0], acc[1], acc[2], acc[3]});
  endfunction

  function automatic bit m_err();
    return (acc.size() >= 4) && (m_n() > DEPTH);
  endfunction

  function automatic bit m_run();
    if (acc.size() < 4 || m_err()) return 1'b0;
    return longint'(acc.size()) >= 4 + 4 * m_n();
  endfunction

  function automatic bit m_ready();
    return !(m_run() || m_err());
  endfunction

  function automatic logic [31:0] m_inst(input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 2) % DEPTH);
    if (!m_run() || idx >= m_n()) return 32'd0;
    return {acc[4+4*idx], acc[5+4*idx], acc[6+4*idx], acc[7+4*idx]};
  endfunction

  // Random address: index near the loaded range, random offset and upper bits.
  function automatic logic [31:0] rand_pc();
    longint hi;
    logic [31:0] idx;
    hi  = (m_n() > 1030) ? 1030 : m_n() + 1;
    idx = $urandom_range(0, int'(hi));
    return ($urandom() & 32'hFFFF_F000) | (idx << 2) | 32'($urandom_range(0, 3));
  endfunction

  // ---- stimulus --------------------------------------------------------
  // One clock cycle: drive, check outputs mid-cycle, then let the edge land.
  task automatic step(input bit v, input logic [7:0] d);
    logic [31:0] pc;
    pc = rand_pc();
    rx_valid = v;
    rx_data = d;
    program_counter = pc;
    #4;
    check("rx_ready", 32'(rx_ready), 32'(m_ready()));
    check("load_done", 32'(load_done), 32'(m_run()));
    check("core_rstn", 32'(core_rstn), 32'(m_run()));
    check("load_err", 32'(load_err), 32'(m_err()));
    check("inst", inst, m_inst(pc));
    @(posedge clk);
    if (v && m_ready()) acc.push_back(d);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    rx_valid = 1'b0;
    program_counter = 32'd0;
    #2;
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_core", 32'(core_rstn), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_inst", inst, 32'd0);
    acc.delete();
    #5;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // mode 0: back-to-back, 1: idle between bytes, 2: random idles
  task automatic send(input int mode);
    for (int i = 0; i < strm.size(); i++) begin
      if (mode == 2) begin
        while ($urandom_range(0, 2) == 0) step(1'b0, 8'($urandom()));
      end
      step(1'b1, strm[i]);
      if (mode == 1 && i != strm.size() - 1) step(1'b0, 8'($urandom()));
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    strm.push_back(w[31:24]);
    strm.push_back(w[23:16]);
    strm.push_back(w[15:8]);
    strm.push_back(w[7:0]);
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    program_counter = pc;
    #1;
    check(tag, inst, exp);
  endtask

  task automatic build_ref();
    strm.delete();
    push_word(32'd2);
    push_word(32'h2001_0005);
    push_word(32'h0022_1820);
  endtask

  task automatic check_ref(input string p);
    check({p, "_done"}, 32'(load_done), 32'd1);
    check({p, "_core"}, 32'(core_rstn), 32'd1);
    check({p, "_rdy"}, 32'(rx_ready), 32'd0);
    probe({p, "_pc0"}, 32'd0, 32'h2001_0005);
    probe({p, "_pc4"}, 32'd4, 32'h0022_1820);
    probe({p, "_pc8"}, 32'd8, 32'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] n;
    rx_data = 8'd0;
    do_reset();

    // Reference two-word program, back-to-back.
    build_ref();
    send(0);
    check_ref("t27");
    // Low address bits ignored, upper bits masked.
    probe("t32_pc6", 32'h0000_0006, 32'h0022_1820);
    probe("t32_pc1004", 32'h0000_1004, 32'h0022_1820);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom()));

    // Same program with valid toggling; completion after 23 cycles.
    do_reset();
    build_ref();
    cyc = 0;
    for (int i = 0; i < strm.size(); i++) begin
      step(1'b1, strm[i]);
      cyc++;
      if (i != strm.size() - 1) begin
        step(1'b0, 8'($urandom()));
        cyc++;
      end
    end
    check("t28_cycles", 32'(cyc), 32'd23);
    check_ref("t28");

    // Empty program: running immediately, everything reads nop.
    do_reset();
    strm.delete();
    push_word(32'd0);
    send(0);
    check("t29_done", 32'(load_done), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom()));

    // Count one beyond depth: error, terminal.
    do_reset();
    strm.delete();
    push_word(32'h0000_0401);
    send(0);
    check("t30_err", 32'(load_err), 32'd1);
    check("t30_core", 32'(core_rstn), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom()));

    // Reset in the middle of loading, then a full reload.
    do_reset();
    build_ref();
    for (int i = 0; i < 6; i++) step(1'b1, strm[i]);
    do_reset();
    send(2);
    check_ref("t31");

    // Random programs with random idles and trailing bytes.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      strm.delete();
      n = 32'($urandom_range(1, 12));
      push_word(n);
      for (int i = 0; i < int'(n); i++) push_word($urandom());
      for (int i = 0; i < 3; i++) strm.push_back(8'($urandom()));
      send(2);
      for (int i = 0; i < 10; i++) step(1'b0, 8'd0);
    end

    // Random oversized counts.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      strm.delete();
      push_word(32'(DEPTH + 1) + $urandom_range(0, 100000));
      for (int i = 0; i < 6; i++) strm.push_back(8'($urandom()));
      send(2);
    end

    // Full-depth program.
    do_reset();
    strm.delete();
    push_word(32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) push_word($urandom());
    send(0);
    check("tfull_done", 32'(load_done), 32'd1);
    probe("tfull_last", 32'((DEPTH - 1) * 4), m_inst(32'((DEPTH - 1) * 4)));
    probe("tfull_first", 32'd0, m_inst(32'd0));
    for (int i = 0; i < 20; i++) step(1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
